sipo_rx: RTL and testbench

- Serial-in, parallel-out frame receiver. Counterpart to the team's serial transmit shift register.
- Collects `size` serial bits, least-significant bit first. Shifting is gated by `en`; the start of each frame is marked by `sync`.
- Presents each completed word on `dout` with a valid/ack handshake.
- Sits at the receiving end of the serial link and feeds parallel consumers (register files, checkers).

---
 rtl/sipo_rx.sv | 130 +++++++++++++
 tb/tb_sipo_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in, parallel-out frame receiver.
// Collects `size` bits LSB first while en=1, frame start marked by sync,
// and presents each completed word on dout with a valid/ack handshake.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   en              bit strobe qualifying si and sync
//   si              serial data bit
//   sync            current bit is bit 0 of a new frame
//   ack             consumer accepts dout while dout_valid=1
//   dout            last completed word
//   dout_valid      dout holds an unconsumed word
//   busy            frame partially received
//   ovr             sticky overrun (word overwritten before ack)
//   sync_err        one-cycle pulse after a frame is aborted by early sync
module sipo_rx #(
    parameter int unsigned size = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            si,
    input  logic            sync,
    input  logic            ack,
    output logic [size-1:0] dout,
    output logic            dout_valid,
    output logic            busy,
    output logic            ovr,
    output logic            sync_err
);

    localparam int unsigned CW = $clog2(size + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    // Only the upper size-1 bits of the word are ever re-read: on the last
    // bit the word is assembled directly from si and these bits.
    logic [size-2:0] shreg;
    logic [size-1:0] shifted;
    logic            shift;
    logic            complete;
    logic            abort;
    logic            accept;

    assign shifted = {si, shreg};
    assign busy    = (state == RECV);
    assign accept  = ack && dout_valid;

    // Next-state and control decode
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        shift    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (sync) begin
                        shift   = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (sync) begin
                        // Early sync restarts the frame with this bit as bit 0
                        abort = 1'b1;
                        shift = 1'b1;
                        cnt_d = CW'(1);
                    end else if (cnt == CW'(size - 1)) begin
                        shift    = 1'b1;
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        shift = 1'b1;
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register, shift register and bit counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (shift) begin
                shreg <= shifted[size-1:1];
            end
        end
    end

    // Output word, handshake and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovr        <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= abort;
            if (complete) begin
                dout       <= shifted;
                dout_valid <= 1'b1;
                // Pending word either consumed this edge or lost
                if (dout_valid) begin
                    ovr <= !ack;
                end
            end else if (accept) begin
                dout_valid <= 1'b0;
                ovr        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx (size=4): scoreboard of expected words, popped
// whenever the receiver presents a new word.
module tb_sipo_rx;

    localparam int unsigned SIZE = 4;

    logic            clk;
    logic            rstn;
    logic            en;
    logic            si;
    logic            sync;
    logic            ack;
    logic [SIZE-1:0] dout;
    logic            dout_valid;
    logic            busy;
    logic            ovr;
    logic            sync_err;

    int checks;
    int failures;

    logic [SIZE-1:0] exp_q[$];
    logic            prev_valid;
    logic [SIZE-1:0] prev_dout;

    sipo_rx #(.size(SIZE)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .si         (si),
        .sync       (sync),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovr        (ovr),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one bit; returns 1 time unit after the edge that samples it.
    task automatic drive_bit(input logic b, input logic s, input logic a);
        en   = 1'b1;
        si   = b;
        sync = s;
        ack  = a;
        @(posedge clk);
        #1;
        en   = 1'b0;
        sync = 1'b0;
        ack  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    // Full frame, LSB first, sync on bit 0; optional ack on the last-bit edge.
    task automatic send_frame(input logic [SIZE-1:0] w, input logic gaps, input logic ack_last);
        for (int i = 0; i < int'(SIZE); i++) begin
            if (i == int'(SIZE) - 1) exp_q.push_back(w);
            drive_bit(w[i], i == 0, (i == int'(SIZE) - 1) ? ack_last : 1'b0);
            if (gaps && i < int'(SIZE) - 1) idle_cycle();
        end
    endtask

    // Scoreboard monitor: a new word is a rising valid or a changed dout while valid.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
            prev_dout  = '0;
        end else begin
            if (dout_valid && (!prev_valid || dout !== prev_dout)) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    check_val("word", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = dout_valid;
            prev_dout  = dout;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        prev_valid = 1'b0;
        prev_dout  = '0;
        rstn = 1'b0;
        en   = 1'b0;
        si   = 1'b0;
        sync = 1'b0;
        ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout", 32'(dout), 32'h0);
        check_val("rst_valid", 32'(dout_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_ovr", 32'(ovr), 32'h0);
        rstn = 1'b1;
        idle_cycle();

        // Reset mid-frame, asserted away from any clock edge
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_val("pre_rst_busy", 32'(busy), 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        check_val("async_rst_busy", 32'(busy), 32'h0);
        check_val("async_rst_valid", 32'(dout_valid), 32'h0);
        check_val("async_rst_dout", 32'(dout), 32'h0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_frame(4'h5, 1'b0, 1'b0);
        check_val("after_rst_valid", 32'(dout_valid), 32'h1);
        check_val("after_rst_dout", 32'(dout), 32'h5);
        do_ack();

        // Basic frame 1,1,0,1 with busy tracking
        for (int i = 0; i < 4; i++) begin
            logic [3:0] w;
            w = 4'hB;
            if (i == 3) exp_q.push_back(w);
            check_val("basic_valid_pre", 32'(dout_valid), 32'h0);
            drive_bit(w[i], i == 0, 1'b0);
            check_val("basic_busy", 32'(busy), (i < 3) ? 32'h1 : 32'h0);
        end
        check_val("basic_valid", 32'(dout_valid), 32'h1);
        check_val("basic_dout", 32'(dout), 32'hB);
        do_ack();
        check_val("ack_valid", 32'(dout_valid), 32'h0);
        check_val("ack_dout_held", 32'(dout), 32'hB);
        do_ack();
        check_val("ack_idle_valid", 32'(dout_valid), 32'h0);

        // Unsynced bits ignored, en gaps ignored
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_val("unsynced_busy", 32'(busy), 32'h0);
        send_frame(4'hC, 1'b1, 1'b0);
        check_val("gaps_dout", 32'(dout), 32'hC);
        check_val("gaps_ovr", 32'(ovr), 32'h0);
        do_ack();

        // Early sync aborts the partial frame
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_val("early_err_before", 32'(sync_err), 32'h0);
        check_val("early_valid_partial", 32'(dout_valid), 32'h0);
        drive_bit(1'b0, 1'b1, 1'b0);
        check_val("early_err_pulse", 32'(sync_err), 32'h1);
        check_val("early_busy", 32'(busy), 32'h1);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_val("early_err_clear", 32'(sync_err), 32'h0);
        drive_bit(1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'hE);
        drive_bit(1'b1, 1'b0, 1'b0);
        check_val("early_dout", 32'(dout), 32'hE);
        check_val("early_err_end", 32'(sync_err), 32'h0);
        do_ack();

        // Overrun: two back-to-back frames without ack
        send_frame(4'h3, 1'b0, 1'b0);
        check_val("ovr_first", 32'(ovr), 32'h0);
        send_frame(4'h9, 1'b0, 1'b0);
        check_val("ovr_dout", 32'(dout), 32'h9);
        check_val("ovr_set", 32'(ovr), 32'h1);
        check_val("ovr_valid", 32'(dout_valid), 32'h1);
        idle_cycle();
        check_val("ovr_sticky", 32'(ovr), 32'h1);
        do_ack();
        check_val("ovr_cleared", 32'(ovr), 32'h0);
        check_val("ovr_ack_valid", 32'(dout_valid), 32'h0);

        // Ack coincident with completion
        send_frame(4'h1, 1'b0, 1'b0);
        idle_cycle();
        send_frame(4'h6, 1'b0, 1'b1);
        check_val("simul_dout", 32'(dout), 32'h6);
        check_val("simul_valid", 32'(dout_valid), 32'h1);
        check_val("simul_ovr", 32'(ovr), 32'h0);
        do_ack();
        check_val("simul_final_valid", 32'(dout_valid), 32'h0);

        repeat (2) idle_cycle();
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
